// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } arb_gnt_t;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_pick.sv
// Combinational grant selector for the memory port arbiter.
// Define MEM_ARB_RR_EN for round-robin; otherwise data has fixed priority over fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic     i_req,
    input  logic     d_req,
    input  arb_gnt_t last_gnt,
    output logic     gnt_valid,
    output arb_gnt_t gnt
);

`ifndef MEM_ARB_RR_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    always_comb begin
        gnt_valid = i_req | d_req;
        gnt       = GNT_I;
`ifdef MEM_ARB_RR_EN
        // On a tie, the port that did not own the memory last time wins.
        if (i_req && d_req) begin
            gnt = (last_gnt == GNT_D) ? GNT_I : GNT_D;
        end else if (d_req) begin
            gnt = GNT_D;
        end
`else
        // The MEM-stage instruction is older, so data goes first.
        if (d_req) begin
            gnt = GNT_D;
        end
`endif
    end

endmodule : mem_arb_pick

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle single-port memory between instruction fetch and data access.
// Optional round-robin arbitration is enabled with MEM_ARB_RR_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_kill,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    arb_gnt_t          gnt_q, gnt_d;
    logic              kill_q, kill_d;
    logic              kill_now;
    logic              m_en_q, m_en_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;

    logic              pick_valid;
    arb_gnt_t          pick_gnt;
    arb_gnt_t          last_gnt;

`ifdef MEM_ARB_RR_EN
    arb_gnt_t          last_gnt_q, last_gnt_d;
    assign last_gnt = last_gnt_q;
`else
    assign last_gnt = GNT_I;
`endif

    mem_arb_pick u_pick (
        .i_req     (i_req),
        .d_req     (d_req),
        .last_gnt  (last_gnt),
        .gnt_valid (pick_valid),
        .gnt       (pick_gnt)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        kill_d    = kill_q;
        m_en_d    = m_en_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        kill_now  = kill_q;
`ifdef MEM_ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (pick_valid) begin
                    gnt_d   = pick_gnt;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    m_en_d  = 1'b1;
                    state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_gnt_d = pick_gnt;
`endif
                    if (pick_gnt == GNT_D) begin
                        m_addr_d  = d_addr;
                        m_we_d    = d_we;
                        m_wdata_d = d_wdata;
                    end else begin
                        m_addr_d  = i_addr;
                        m_we_d    = 1'b0;
                        m_wdata_d = '0;
                    end
                end
            end

            ACCESS: begin
                // A kill in the final access cycle must still suppress the response.
                kill_now = kill_q | (i_kill & (gnt_q == GNT_I));
                kill_d   = kill_now;
                if (cnt_q == '0) begin
                    state_d = RESP;
                    m_en_d  = 1'b0;
                    m_we_d  = 1'b0;
                    if (gnt_q == GNT_D) begin
                        d_ready_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end else if (!kill_now) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RESP: begin
                kill_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                m_en_d  = 1'b0;
                m_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt_q     <= GNT_I;
            kill_q    <= 1'b0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_gnt_q <= GNT_I;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            kill_q    <= kill_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
`ifdef MEM_ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    assign i_rdata = i_rdata_q;
    assign i_ready = i_ready_q;
    assign d_rdata = d_rdata_q;
    assign d_ready = d_ready_q;
    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

    // Stalls feed the hazard unit directly.
    assign i_stall = i_req & ~i_ready_q;
    assign d_stall = d_req & ~d_ready_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instances with LATENCY 2, 3 and 1.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock;
    logic        reset   [3];
    logic        i_req   [3];
    logic        i_kill  [3];
    logic        d_req   [3];
    logic        d_we    [3];
    logic [31:0] i_addr  [3];
    logic [31:0] d_addr  [3];
    logic [31:0] d_wdata [3];
    logic [31:0] m_rdata [3];
    logic [31:0] i_rdata [3];
    logic [31:0] d_rdata [3];
    logic [31:0] m_addr  [3];
    logic [31:0] m_wdata [3];
    logic        i_ready [3];
    logic        i_stall [3];
    logic        d_ready [3];
    logic        d_stall [3];
    logic        m_en    [3];
    logic        m_we    [3];

    int vectors = 0;
    int errs    = 0;
    int n;
    bit seen_i, seen_d, i_first;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h4:   return 32'h20010005;
            32'h10:  return 32'hCAFE0010;
            default: return a ^ 32'h5A5A0000;
        endcase
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int unsigned LAT = (k == 0) ? 2 : ((k == 1) ? 3 : 1);
        mem_port_arbiter #(.LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) u_dut (
            .clock   (clock),
            .reset   (reset[k]),
            .i_req   (i_req[k]),
            .i_addr  (i_addr[k]),
            .i_kill  (i_kill[k]),
            .i_rdata (i_rdata[k]),
            .i_ready (i_ready[k]),
            .i_stall (i_stall[k]),
            .d_req   (d_req[k]),
            .d_we    (d_we[k]),
            .d_addr  (d_addr[k]),
            .d_wdata (d_wdata[k]),
            .d_rdata (d_rdata[k]),
            .d_ready (d_ready[k]),
            .d_stall (d_stall[k]),
            .m_en    (m_en[k]),
            .m_we    (m_we[k]),
            .m_addr  (m_addr[k]),
            .m_wdata (m_wdata[k]),
            .m_rdata (m_rdata[k])
        );
        // Memory model: data only meaningful while the port is enabled.
        assign m_rdata[k] = m_en[k] ? mem_word(m_addr[k]) : 32'hBAD0BAD0;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            reset[k] = 1'b1; i_req[k] = 1'b0; i_kill[k] = 1'b0; d_req[k] = 1'b0;
            d_we[k] = 1'b0; i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            chk1("rst_m_en", m_en[k], 1'b0);
            chk1("rst_m_we", m_we[k], 1'b0);
            chk1("rst_i_ready", i_ready[k], 1'b0);
            chk1("rst_d_ready", d_ready[k], 1'b0);
            chk("rst_m_addr", m_addr[k], 32'h0);
            chk("rst_i_rdata", i_rdata[k], 32'h0);
            reset[k] = 1'b0;
        end
        tick();

        // 1: single fetch, LATENCY=2
        i_req[0] = 1'b1; i_addr[0] = 32'h4;
        #1 chk1("t1_stall_c0", i_stall[0], 1'b1);
        tick();
        chk1("t1_m_en_c1", m_en[0], 1'b1);
        chk("t1_m_addr_c1", m_addr[0], 32'h4);
        chk1("t1_m_we_c1", m_we[0], 1'b0);
        chk1("t1_stall_c1", i_stall[0], 1'b1);
        tick();
        chk1("t1_m_en_c2", m_en[0], 1'b1);
        chk1("t1_ready_c2", i_ready[0], 1'b0);
        chk1("t1_stall_c2", i_stall[0], 1'b1);
        tick();
        chk1("t1_m_en_c3", m_en[0], 1'b0);
        chk1("t1_ready_c3", i_ready[0], 1'b1);
        chk("t1_rdata_c3", i_rdata[0], 32'h20010005);
        chk1("t1_stall_c3", i_stall[0], 1'b0);
        i_req[0] = 1'b0;
        tick();
        chk1("t1_ready_c4", i_ready[0], 1'b0);

        // 2: simultaneous load and fetch, data first
        i_req[0] = 1'b1; i_addr[0] = 32'h8;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h10;
        tick();
        chk("t2_m_addr_c1", m_addr[0], 32'h10);
        chk1("t2_i_stall_c1", i_stall[0], 1'b1);
        chk1("t2_d_stall_c1", d_stall[0], 1'b1);
        tick();
        tick();
        chk1("t2_d_ready_c3", d_ready[0], 1'b1);
        chk("t2_d_rdata_c3", d_rdata[0], 32'hCAFE0010);
        chk1("t2_i_ready_c3", i_ready[0], 1'b0);
        d_req[0] = 1'b0;
        tick();
        chk1("t2_m_en_c4", m_en[0], 1'b0);
        chk1("t2_d_ready_c4", d_ready[0], 1'b0);
        tick();
        chk1("t2_m_en_c5", m_en[0], 1'b1);
        chk("t2_m_addr_c5", m_addr[0], 32'h8);
        tick();
        chk1("t2_i_ready_c6", i_ready[0], 1'b0);
        tick();
        chk1("t2_i_ready_c7", i_ready[0], 1'b1);
        chk("t2_i_rdata_c7", i_rdata[0], 32'h5A5A0008);
        i_req[0] = 1'b0;
        tick();

        // 3: store holds m_* stable for LATENCY cycles
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h20; d_wdata[0] = 32'hDEADBEEF;
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk1("t3_m_en", m_en[0], 1'b1);
            chk1("t3_m_we", m_we[0], 1'b1);
            chk("t3_m_addr", m_addr[0], 32'h20);
            chk("t3_m_wdata", m_wdata[0], 32'hDEADBEEF);
            chk1("t3_d_ready_early", d_ready[0], 1'b0);
        end
        tick();
        chk1("t3_m_en_c3", m_en[0], 1'b0);
        chk1("t3_m_we_c3", m_we[0], 1'b0);
        chk1("t3_d_ready_c3", d_ready[0], 1'b1);
        chk("t3_d_rdata_kept", d_rdata[0], 32'hCAFE0010);
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        tick();
        chk1("t3_d_ready_c4", d_ready[0], 1'b0);

        // 2b: tie right after a data grant (round-robin favours fetch)
        i_req[0] = 1'b1; i_addr[0] = 32'h4;
        d_req[0] = 1'b1; d_addr[0] = 32'h30;
        tick();
        chk("t2b_first_addr", m_addr[0], RR ? 32'h4 : 32'h30);
        seen_i = 1'b0; seen_d = 1'b0; i_first = 1'b0; n = 0;
        while (!(seen_i && seen_d) && n < 20) begin
            tick();
            n++;
            if (i_ready[0]) begin
                if (!seen_d) i_first = 1'b1;
                seen_i = 1'b1; i_req[0] = 1'b0;
            end
            if (d_ready[0]) begin
                seen_d = 1'b1; d_req[0] = 1'b0;
            end
        end
        chk1("t2b_both_done", seen_i && seen_d, 1'b1);
        chk1("t2b_fetch_first", i_first, RR);
        chk("t2b_d_rdata", d_rdata[0], 32'h5A5A0030);
        chk("t2b_i_rdata", i_rdata[0], 32'h20010005);
        tick();

        // 4: kill in the first access cycle
        i_req[0] = 1'b1; i_addr[0] = 32'h8;
        tick();
        chk1("t4_m_en_c1", m_en[0], 1'b1);
        i_kill[0] = 1'b1;
        tick();
        i_kill[0] = 1'b0;
        chk1("t4_m_en_c2", m_en[0], 1'b1);
        tick();
        chk1("t4_m_en_c3", m_en[0], 1'b0);
        chk1("t4_no_ready", i_ready[0], 1'b0);
        chk("t4_rdata_kept", i_rdata[0], 32'h20010005);
        i_addr[0] = 32'h10;
        tick();
        chk1("t4_m_en_c4", m_en[0], 1'b0);
        tick();
        chk1("t4_m_en_c5", m_en[0], 1'b1);
        chk("t4_m_addr_c5", m_addr[0], 32'h10);
        tick(); tick();
        chk1("t4_ready_c7", i_ready[0], 1'b1);
        chk("t4_rdata_c7", i_rdata[0], 32'hCAFE0010);
        i_req[0] = 1'b0;
        tick();

        // 5: reset during the second access cycle, LATENCY=3
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h10;
        tick();
        chk1("t5_m_en_c1", m_en[1], 1'b1);
        tick();
        reset[1] = 1'b1;
        tick();
        chk1("t5_m_en_rst", m_en[1], 1'b0);
        chk("t5_m_addr_rst", m_addr[1], 32'h0);
        chk1("t5_d_ready_rst", d_ready[1], 1'b0);
        chk("t5_d_rdata_rst", d_rdata[1], 32'h0);
        chk1("t5_d_stall_rst", d_stall[1], 1'b1);
        reset[1] = 1'b0;
        tick();
        chk1("t5_m_en_c4", m_en[1], 1'b1);
        chk("t5_m_addr_c4", m_addr[1], 32'h10);
        chk1("t5_d_ready_c4", d_ready[1], 1'b0);
        tick(); tick();
        chk1("t5_m_en_c6", m_en[1], 1'b1);
        chk1("t5_d_ready_c6", d_ready[1], 1'b0);
        tick();
        chk1("t5_d_ready_c7", d_ready[1], 1'b1);
        chk("t5_d_rdata_c7", d_rdata[1], 32'hCAFE0010);
        d_req[1] = 1'b0;
        tick();

        // 6: LATENCY=1 back-to-back fetches
        i_req[2] = 1'b1; i_addr[2] = 32'h4;
        for (int a = 0; a < 3; a++) begin
            tick();
            chk1("t6_m_en_acc", m_en[2], 1'b1);
            chk1("t6_ready_acc", i_ready[2], 1'b0);
            tick();
            chk1("t6_m_en_resp", m_en[2], 1'b0);
            chk1("t6_ready_resp", i_ready[2], 1'b1);
            chk("t6_rdata", i_rdata[2], mem_word(32'(4 * (a + 1))));
            i_addr[2] = 32'(4 * (a + 2));
            if (a == 2) i_req[2] = 1'b0;
            tick();
            chk1("t6_m_en_idle", m_en[2], 1'b0);
            chk1("t6_ready_idle", i_ready[2], 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule : tb_mem_port_arbiter
